// File: rtl/pbit_sampler.sv
// pbit_sampler: sequential p-bit update engine (linear-clamp sigmoid against a 16-bit Galois LFSR).
// Optional clamping of nodes to fixed values is enabled by defining PBIT_CLAMP_EN.
module pbit_sampler #(
  parameter int          N_NODES   = 8,
  parameter int          IDX_W     = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [IDX_W-1:0]   act_idx,
  input  logic [3:0]         act_in,
  input  logic [1:0]         beta_shift,
`ifdef PBIT_CLAMP_EN
  input  logic [N_NODES-1:0] clamp_mask,
  input  logic [N_NODES-1:0] clamp_val,
`endif
  output logic [N_NODES-1:0] states,
  output logic               upd_valid,
  output logic [IDX_W-1:0]   upd_idx,
  output logic               upd_bit,
  output logic               sweep_done,
  output logic [15:0]        sweep_count
);

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N_NODES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);
  localparam logic [15:0]      TAPS     = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    WRITE
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic signed [3:0]  act_reg;
  logic [1:0]         beta_reg;
  logic [15:0]        lfsr_reg;
  logic [15:0]        lfsr_next;
  logic [N_NODES-1:0] states_reg;
  logic [N_NODES-1:0] states_next;
  logic               upd_valid_reg;
  logic [IDX_W-1:0]   upd_idx_reg;
  logic               upd_bit_reg;
  logic               sweep_done_reg;
  logic [15:0]        sweep_count_reg;

  logic               accept;
  logic signed [11:0] scaled;
  logic signed [11:0] sum;
  logic [8:0]         threshold;
  logic               decision;
  logic               in_range;
  logic               is_last;
  logic               write_en;
  logic               write_bit;
  logic [N_NODES-1:0] sel;
  logic [N_NODES-1:0] node_bit;

  assign act_ready = rst_n && (state_reg == IDLE);
  assign accept    = act_valid && act_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SAMPLE;
      SAMPLE:  state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slope is 16 * 2^beta; the worst case (-8 << 7 = -1024) fits in 12 signed bits.
  always_comb begin
    scaled    = 12'(signed'({{8{act_reg[3]}}, act_reg}) <<< (3'd4 + 3'(beta_reg)));
    sum       = 12'sd128 + scaled;
    threshold = 9'd0;
    if (sum < 12'sd0)        threshold = 9'd0;
    else if (sum > 12'sd256) threshold = 9'd256;
    else                     threshold = sum[8:0];
  end

  assign decision  = ({1'b0, lfsr_reg[7:0]} < threshold);
  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);

  assign in_range = ({1'b0, idx_reg} < N_LIM);
  assign is_last  = (idx_reg == LAST_IDX);
  assign write_en = (state_reg == SAMPLE) && in_range;

  // Per-node address decode and the value each node would take if selected.
  generate
    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_node
      localparam logic [IDX_W-1:0] GI = IDX_W'(gi);
      assign sel[gi] = write_en && (idx_reg == GI);
`ifdef PBIT_CLAMP_EN
      assign node_bit[gi] = clamp_mask[gi] ? clamp_val[gi] : decision;
`else
      assign node_bit[gi] = decision;
`endif
    end
  endgenerate

`ifdef PBIT_CLAMP_EN
  assign write_bit = (|(sel & clamp_mask)) ? (|(sel & clamp_val)) : decision;
`else
  assign write_bit = decision;
`endif

  assign states_next = (states_reg & ~sel) | (sel & node_bit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      act_reg         <= '0;
      beta_reg        <= '0;
      lfsr_reg        <= SEED_EFF;
      states_reg      <= '0;
      upd_valid_reg   <= 1'b0;
      upd_idx_reg     <= '0;
      upd_bit_reg     <= 1'b0;
      sweep_done_reg  <= 1'b0;
      sweep_count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        idx_reg  <= act_idx;
        act_reg  <= act_in;
        beta_reg <= beta_shift;
      end
      if (state_reg == SAMPLE) begin
        lfsr_reg <= lfsr_next;
      end
      states_reg     <= states_next;
      upd_valid_reg  <= write_en;
      sweep_done_reg <= write_en && is_last;
      if (write_en) begin
        upd_idx_reg <= idx_reg;
        upd_bit_reg <= write_bit;
        if (is_last) sweep_count_reg <= sweep_count_reg + 16'd1;
      end
    end
  end

  assign states      = states_reg;
  assign upd_valid   = upd_valid_reg;
  assign upd_idx     = upd_idx_reg;
  assign upd_bit     = upd_bit_reg;
  assign sweep_done  = sweep_done_reg;
  assign sweep_count = sweep_count_reg;

endmodule

// File: tb/tb_pbit_sampler.sv
// Directed testbench for pbit_sampler with a reference sigmoid/LFSR model and a result scoreboard.
module tb_pbit_sampler;
  localparam int N  = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          act_valid;
  logic          act_ready;
  logic [IW-1:0] act_idx;
  logic [3:0]    act_in;
  logic [1:0]    beta_shift;
  logic [N-1:0]  states;
  logic          upd_valid;
  logic [IW-1:0] upd_idx;
  logic          upd_bit;
  logic          sweep_done;
  logic [15:0]   sweep_count;
`ifdef PBIT_CLAMP_EN
  logic [N-1:0]  clamp_mask = '0;
  logic [N-1:0]  clamp_val  = '0;
`endif

  always #5 clk = ~clk;

  pbit_sampler #(.N_NODES(N), .IDX_W(IW), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_idx(act_idx), .act_in(act_in), .beta_shift(beta_shift),
`ifdef PBIT_CLAMP_EN
    .clamp_mask(clamp_mask), .clamp_val(clamp_val),
`endif
    .states(states), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_bit(upd_bit),
    .sweep_done(sweep_done), .sweep_count(sweep_count)
  );

  typedef struct {
    int          idx;
    logic        b;
    logic        sw;
    logic [15:0] cnt;
    logic [N-1:0] st;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;
  logic [N-1:0] m_states;
  logic [15:0] m_lfsr;
  logic [15:0] m_sweeps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_states = '0;
    m_lfsr   = 16'hACE1;
    m_sweeps = 16'd0;
    sb.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    act_valid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rst_ready", act_ready, 1'b0);
      check("rst_upd_valid", upd_valid, 1'b0);
    end
    check("rst_states", states, '0);
    check("rst_sweep_count", sweep_count, 16'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_ready", act_ready, 1'b1);
    check("post_rst_states", states, '0);
  endtask

  // One handshake, then follow the transaction through SAMPLE and WRITE.
  task automatic accept(input int idx, input int act, input int beta);
    int          n;
    int          thr;
    logic        b;
    logic        inr;
    logic [3:0]  a4;
    exp_t        e;
    n = 0;
    while (!act_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", act_ready, 1'b1);
    thr = 128 + act * 16 * (1 << beta);
    if (thr < 0)   thr = 0;
    if (thr > 256) thr = 256;
    b = (int'(m_lfsr[7:0]) < thr);
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    inr = (idx < N);
    if (inr) begin
      m_states[idx] = b;
      if (idx == N - 1) m_sweeps = m_sweeps + 16'd1;
      e.idx = idx; e.b = b; e.sw = (idx == N - 1); e.cnt = m_sweeps; e.st = m_states;
      sb.push_back(e);
    end
    a4 = act[3:0];
    act_valid  = 1'b1;
    act_idx    = idx[IW-1:0];
    act_in     = a4;
    beta_shift = beta[1:0];
    @(posedge clk);
    @(negedge clk);
    act_valid = 1'b0;
    act_in    = 4'($urandom);
    act_idx   = IW'($urandom);
    check("sample_ready", act_ready, 1'b0);
    check("sample_upd_valid", upd_valid, 1'b0);
    @(negedge clk);
    check("write_ready", act_ready, 1'b0);
    if (sweep_done) pulses++;
    if (inr) begin
      e = sb.pop_front();
      check("upd_valid", upd_valid, 1'b1);
      check("upd_idx", upd_idx, e.idx);
      check("upd_bit", upd_bit, e.b);
      check("sweep_done", sweep_done, e.sw);
      check("sweep_count", sweep_count, e.cnt);
      check("states", states, e.st);
    end else begin
      check("oor_upd_valid", upd_valid, 1'b0);
      check("oor_sweep_done", sweep_done, 1'b0);
      check("oor_states", states, m_states);
      check("oor_sweep_count", sweep_count, m_sweeps);
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; act_valid = 1'b0; act_idx = '0; act_in = '0; beta_shift = '0;
    model_reset();

    do_reset(2);
    accept(2, 1, 0);              // threshold 144 vs 225
    do_reset(2);
    accept(2, 7, 0);              // threshold 240 vs 225
    accept(5, 0, 1);

    for (int i = 0; i < 1000; i++) accept($urandom_range(0, N - 1), -8, 3);
    for (int i = 0; i < 1000; i++) accept($urandom_range(0, N - 1), 1, 3);

    do_reset(2);
    pulses = 0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++)
        accept(i, int'($urandom_range(0, 15)) - 8, $urandom_range(0, 3));
    check("sweep_pulses", pulses, 3);
    check("sweep_count_final", sweep_count, 16'd3);
    accept(9, 7, 3);
    check("sweep_pulses_after_oor", pulses, 3);

    // Reset asserted during SAMPLE abandons the transaction.
    @(negedge clk);
    act_valid = 1'b1; act_idx = 4'd2; act_in = 4'd1; beta_shift = 2'd0;
    @(posedge clk);
    @(negedge clk);
    act_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_upd_valid", upd_valid, 1'b0);
    check("midrst_states", states, '0);
    check("midrst_ready", act_ready, 1'b0);
    @(negedge clk);
    check("midrst_upd_valid2", upd_valid, 1'b0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_release_ready", act_ready, 1'b1);
    accept(2, 1, 0);
    accept(2, 7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
